// File: rtl/dmem_responder.sv
// Fixed-latency, word-organised data memory that answers the MEM-stage port.
// One request at a time: IDLE captures it, BUSY counts down, RESP pulses resp_b.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_b,
  input  logic        write_b,
  input  logic [1:0]  wmask_b,
  input  logic [15:0] address_b,
  input  logic [15:0] wdata_b,
  output logic        resp_b,
  output logic [15:0] rdata_b,
  output logic        busy
);

  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [15:0] IDX_MASK = 16'(((1 << ADDR_WIDTH) - 1) << 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    resp_q;
  logic                    busy_q;
  logic [15:0]             rdata_q;

  logic                    is_write_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [15:0]             wdata_q;
  logic [1:0]              wmask_q;

  logic [15:0]             mem_q [DEPTH];

  logic                    req_in;
  logic [ADDR_WIDTH-1:0]   addr_idx;
  logic                    unused_addr_bits;
  logic                    rd_is_write_d;
  logic [ADDR_WIDTH-1:0]   rd_idx_d;
  logic [15:0]             rdata_d;
  logic [15:0]             wword_d;

  assign req_in           = read_b | write_b;
  assign addr_idx         = address_b[ADDR_WIDTH:1];
  // Byte-select bit and the bits above the index alias onto the same word.
  assign unused_addr_bits = ^(address_b & ~IDX_MASK);

  // With LATENCY=1 the read happens on the capture edge, so the index and
  // op come straight from the port; otherwise from the captured copy.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latch.
    rd_is_write_d = is_write_q;
    rd_idx_d      = idx_q;
    if (state_q == IDLE) begin
      rd_is_write_d = write_b;
      rd_idx_d      = addr_idx;
    end
    rdata_d = rd_is_write_d ? 16'h0000 : mem_q[rd_idx_d];
  end

  always_comb begin
    wword_d = mem_q[idx_q];
    if (wmask_q[0]) wword_d[7:0]  = wdata_q[7:0];
    if (wmask_q[1]) wword_d[15:8] = wdata_q[15:8];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_q  <= 1'b0;
          rdata_q <= '0;
          if (req_in) begin
            cnt_q  <= CNT_LOAD;
            busy_q <= 1'b1;
            if (CNT_LOAD == 4'd0) begin
              state_q <= RESP;
              resp_q  <= 1'b1;
              rdata_q <= rdata_d;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
            resp_q  <= 1'b1;
            rdata_q <= rdata_d;
          end
        end
        RESP: begin
          state_q <= IDLE;
          resp_q  <= 1'b0;
          rdata_q <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          resp_q  <= 1'b0;
          rdata_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Request capture is pure datapath; the FSM decides whether it is used.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_in) begin
      is_write_q <= write_b;
      idx_q      <= addr_idx;
      wdata_q    <= wdata_b;
      wmask_q    <= wmask_b;
    end
  end

  // NOTE: the array has no reset; contents survive reset like a real SRAM,
  // and only the commit is suppressed when reset aborts a write.
  always_ff @(posedge clk) begin
    if (!reset && state_q == RESP && is_write_q) begin
      mem_q[idx_q] <= wword_d;
    end
  end

  assign resp_b  = resp_q;
  assign rdata_b = rdata_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=2 and one LATENCY=1 instance.
module tb_dmem_responder;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        rd    = 1'b0;
  logic        wr    = 1'b0;
  logic        use1  = 1'b0;
  logic [1:0]  mask  = 2'b00;
  logic [15:0] addr  = 16'h0000;
  logic [15:0] wdata = 16'h0000;

  logic        resp2, busy2, resp1, busy1;
  logic [15:0] rdata2, rdata1;
  logic        cur_resp, cur_busy;
  logic [15:0] cur_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .read_b   (rd & ~use1),
    .write_b  (wr & ~use1),
    .wmask_b  (mask),
    .address_b(addr),
    .wdata_b  (wdata),
    .resp_b   (resp2),
    .rdata_b  (rdata2),
    .busy     (busy2)
  );

  dmem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) u_dut_l1 (
    .clk      (clk),
    .reset    (reset),
    .read_b   (rd & use1),
    .write_b  (wr & use1),
    .wmask_b  (mask),
    .address_b(addr),
    .wdata_b  (wdata),
    .resp_b   (resp1),
    .rdata_b  (rdata1),
    .busy     (busy1)
  );

  assign cur_resp  = use1 ? resp1  : resp2;
  assign cur_busy  = use1 ? busy1  : busy2;
  assign cur_rdata = use1 ? rdata1 : rdata2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full transaction on the selected instance, checking every cycle around resp_b.
  task automatic op(input logic rd_i, input logic wr_i, input logic [1:0] mask_i,
                    input logic [15:0] addr_i, input logic [15:0] wdata_i,
                    input logic [15:0] exp_i, input string tag);
    int lat;
    lat   = use1 ? 1 : 2;
    rd    = rd_i;
    wr    = wr_i;
    mask  = mask_i;
    addr  = addr_i;
    wdata = wdata_i;
    tick();
    for (int i = 1; i < lat; i++) begin
      check({tag, " pre resp_b"}, 16'(cur_resp), 16'h0000);
      check({tag, " pre rdata"}, cur_rdata, 16'h0000);
      tick();
    end
    check({tag, " resp_b"}, 16'(cur_resp), 16'h0001);
    check({tag, " rdata"}, cur_rdata, exp_i);
    rd = 1'b0;
    wr = 1'b0;
    tick();
    check({tag, " post resp_b"}, 16'(cur_resp), 16'h0000);
    check({tag, " post rdata"}, cur_rdata, 16'h0000);
    check({tag, " post busy"}, 16'(cur_busy), 16'h0000);
  endtask

  initial begin
    repeat (3) tick();
    check("reset resp_b", 16'(resp2), 16'h0000);
    check("reset rdata", rdata2, 16'h0000);
    check("reset busy", 16'(busy2), 16'h0000);
    check("reset l1 resp_b", 16'(resp1), 16'h0000);
    check("reset l1 busy", 16'(busy1), 16'h0000);
    reset = 1'b0;
    tick();

    // Full-word write then read back.
    op(1'b0, 1'b1, 2'b11, 16'h0010, 16'hBEEF, 16'h0000, "t1 write");
    op(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'hBEEF, "t1 read");

    // Byte-masked writes.
    op(1'b0, 1'b1, 2'b01, 16'h0010, 16'h12AB, 16'h0000, "t2 wr lo");
    op(1'b1, 1'b0, 2'b11, 16'h0010, 16'h0000, 16'hBEAB, "t2 rd lo");
    op(1'b0, 1'b1, 2'b10, 16'h0010, 16'h3400, 16'h0000, "t2 wr hi");
    op(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'h34AB, "t2 rd hi");
    op(1'b0, 1'b1, 2'b00, 16'h0010, 16'hFFFF, 16'h0000, "t2 wr none");
    op(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'h34AB, "t2 rd none");

    // Held read across two addresses, LATENCY=2: pulses 3 cycles apart.
    op(1'b0, 1'b1, 2'b11, 16'h0012, 16'hA5C3, 16'h0000, "t3 prep");
    rd = 1'b1; addr = 16'h0010;
    tick();
    check("t3 l2 a busy", 16'(resp2), 16'h0000);
    tick();
    check("t3 l2 a resp_b", 16'(resp2), 16'h0001);
    check("t3 l2 a rdata", rdata2, 16'h34AB);
    addr = 16'h0012;
    tick();
    check("t3 l2 gap1 resp_b", 16'(resp2), 16'h0000);
    check("t3 l2 gap1 rdata", rdata2, 16'h0000);
    tick();
    check("t3 l2 gap2 resp_b", 16'(resp2), 16'h0000);
    tick();
    check("t3 l2 b resp_b", 16'(resp2), 16'h0001);
    check("t3 l2 b rdata", rdata2, 16'hA5C3);
    rd = 1'b0;
    tick();
    check("t3 l2 end resp_b", 16'(resp2), 16'h0000);

    // Same on the LATENCY=1 instance: pulses 2 cycles apart.
    use1 = 1'b1;
    op(1'b0, 1'b1, 2'b11, 16'h0010, 16'h1357, 16'h0000, "t3 l1 prep a");
    op(1'b0, 1'b1, 2'b11, 16'h0012, 16'h2468, 16'h0000, "t3 l1 prep b");
    rd = 1'b1; addr = 16'h0010;
    tick();
    check("t3 l1 a resp_b", 16'(resp1), 16'h0001);
    check("t3 l1 a rdata", rdata1, 16'h1357);
    addr = 16'h0012;
    tick();
    check("t3 l1 gap resp_b", 16'(resp1), 16'h0000);
    check("t3 l1 gap rdata", rdata1, 16'h0000);
    tick();
    check("t3 l1 b resp_b", 16'(resp1), 16'h0001);
    check("t3 l1 b rdata", rdata1, 16'h2468);
    rd = 1'b0;
    tick();
    check("t3 l1 end resp_b", 16'(resp1), 16'h0000);
    use1 = 1'b0;

    // Aliasing: upper address bits and bit 0 are ignored.
    op(1'b0, 1'b1, 2'b11, 16'h0210, 16'hCAFE, 16'h0000, "t4 write");
    op(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'hCAFE, "t4 read even");
    op(1'b1, 1'b0, 2'b00, 16'h0011, 16'h0000, 16'hCAFE, "t4 read odd");

    // Reset during BUSY aborts the write.
    op(1'b0, 1'b1, 2'b11, 16'h0020, 16'h1111, 16'h0000, "t5 prep");
    wr = 1'b1; mask = 2'b11; addr = 16'h0020; wdata = 16'h5555;
    tick();
    check("t5 busy high", 16'(busy2), 16'h0001);
    check("t5 no early resp_b", 16'(resp2), 16'h0000);
    reset = 1'b1;
    tick();
    check("t5 abort busy", 16'(busy2), 16'h0000);
    check("t5 abort resp_b", 16'(resp2), 16'h0000);
    reset = 1'b0; wr = 1'b0;
    tick();
    check("t5 after resp_b", 16'(resp2), 16'h0000);
    op(1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, 16'h1111, "t5 read");

    // Reset during RESP: pulse already seen, but the write must not commit.
    op(1'b0, 1'b1, 2'b11, 16'h0030, 16'h7777, 16'h0000, "t5b prep");
    wr = 1'b1; addr = 16'h0030; wdata = 16'h8888;
    tick();
    tick();
    check("t5b resp_b", 16'(resp2), 16'h0001);
    reset = 1'b1; wr = 1'b0;
    tick();
    check("t5b abort busy", 16'(busy2), 16'h0000);
    reset = 1'b0;
    tick();
    op(1'b1, 1'b0, 2'b00, 16'h0030, 16'h0000, 16'h7777, "t5b read");

    // Read and write together behave as a write.
    op(1'b1, 1'b1, 2'b11, 16'h0040, 16'h0F0F, 16'h0000, "t6 rd+wr");
    op(1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, 16'h0F0F, "t6 read");

    // Request dropped and inputs changed while BUSY: captured op still completes.
    wr = 1'b1; mask = 2'b11; addr = 16'h0050; wdata = 16'h6A6A;
    tick();
    wr = 1'b0; addr = 16'h0052; wdata = 16'h0000; mask = 2'b00;
    tick();
    check("t7 dropped resp_b", 16'(resp2), 16'h0001);
    tick();
    check("t7 dropped end", 16'(resp2), 16'h0000);
    op(1'b1, 1'b0, 2'b00, 16'h0050, 16'h0000, 16'h6A6A, "t7 read");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
